// File: rtl/board_io_ctrl.sv
// Board I/O front end: button sync/debounce/press capture, stretched CPU reset,
// and CPU-driven LED pads with polarity control and global PWM dimming.
module board_io_ctrl #(
    parameter int NUM_PB          = 4,
    parameter int NUM_LED         = 8,
    parameter bit PB_ACTIVE_LOW   = 1'b1,
    parameter bit LED_ACTIVE_LOW  = 1'b1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int RESET_PB        = 0,
    parameter int RESET_HOLD      = 16,
    parameter int PWM_BITS        = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_PB-1:0]   pb_pad,
    output logic [NUM_LED-1:0]  led_pad,
    input  logic [31:0]         port_out,
    output logic [31:0]         port_in,
    input  logic [PWM_BITS-1:0] pwm_level,
    output logic [NUM_PB-1:0]   pb_press,
    output logic                cpu_reset
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);

    // Synchroniser chain on the normalised (active-high) button level
    logic [NUM_PB-1:0] pb_norm;
    logic [NUM_PB-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PB-1:0] sync_w;

    assign pb_norm = pb_pad ^ {NUM_PB{PB_ACTIVE_LOW}};
    assign sync_w  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= pb_norm;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    logic [NUM_PB-1:0] stable_q, stable_d;
    logic [NUM_PB-1:0] stable_dly_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PB; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             mismatch;

            // Counter saturates at CNT_MAX; the following mismatching cycle commits the new level
            assign mismatch     = sync_w[gi] ^ stable_q[gi];
            assign cnt_d        = (mismatch && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : '0;
            assign stable_d[gi] = (mismatch && (cnt_q == CNT_MAX)) ? sync_w[gi] : stable_q[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Press pulse, sticky flags and the CPU-visible status word
    logic [NUM_PB-1:0] press_q, press_d;
    logic [NUM_PB-1:0] flag_q, flag_d;
    logic              po31_q;
    logic              flag_clr;
    logic [31:0]       port_in_q, port_in_d;

    assign press_d  = stable_q & ~stable_dly_q;
    assign flag_clr = port_out[31] & ~po31_q;
    assign flag_d   = press_q | (flag_q & ~{NUM_PB{flag_clr}});

    always_comb begin
        port_in_d              = '0;
        port_in_d[NUM_PB-1:0]  = stable_q;
        port_in_d[16 +: NUM_PB] = flag_q;
    end

    // Reset stretcher driven by the debounced reset button
    logic              rst_src;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cpu_reset_q, cpu_reset_d;

    assign rst_src = stable_q[RESET_PB];

    always_comb begin
        hold_d      = hold_q;
        cpu_reset_d = 1'b1;
        if (rst_src) begin
            hold_d = HOLD_INIT;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else begin
            cpu_reset_d = 1'b0;
        end
    end

    // PWM dimming: enable while the free-running counter is at or below the level
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pwm_en;
    logic [NUM_LED-1:0]  led_q, led_d;

    assign pwm_cnt_d = pwm_cnt_q + 1'b1;
    assign pwm_en    = (pwm_cnt_q <= pwm_level);
    assign led_d     = (port_out[NUM_LED-1:0] & {NUM_LED{pwm_en}}) ^ {NUM_LED{LED_ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_q      <= '0;
            flag_q       <= '0;
            po31_q       <= 1'b0;
            port_in_q    <= '0;
            hold_q       <= HOLD_INIT;
            cpu_reset_q  <= 1'b1;
            pwm_cnt_q    <= '0;
            led_q        <= {NUM_LED{LED_ACTIVE_LOW}};
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            flag_q       <= flag_d;
            po31_q       <= port_out[31];
            port_in_q    <= port_in_d;
            hold_q       <= hold_d;
            cpu_reset_q  <= cpu_reset_d;
            pwm_cnt_q    <= pwm_cnt_d;
            led_q        <= led_d;
        end
    end

    logic unused_port_out;
    assign unused_port_out = ^port_out[30:NUM_LED];

    assign led_pad   = led_q;
    assign port_in   = port_in_q;
    assign pb_press  = press_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed vector bench for board_io_ctrl with a 4-cycle debounce, 3-cycle reset
// hold, 2-bit PWM and active-low pads.
module tb_board_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pb_pad;
    logic [7:0]  led_pad;
    logic [31:0] port_out;
    logic [31:0] port_in;
    logic [1:0]  pwm_level;
    logic [3:0]  pb_press;
    logic        cpu_reset;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .NUM_PB(4), .NUM_LED(8), .PB_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b1),
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_PB(0), .RESET_HOLD(3), .PWM_BITS(2)
    ) dut (
        .clk(clk), .reset(reset), .pb_pad(pb_pad), .led_pad(led_pad),
        .port_out(port_out), .port_in(port_in), .pwm_level(pwm_level),
        .pb_press(pb_press), .cpu_reset(cpu_reset)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  pb;
        logic [31:0] po;
        logic [31:0] pin;
        logic [3:0]  press;
        logic        cpu;
    } vec_t;

    vec_t vecs[$];

    function automatic void addn(int n, logic rst, logic [3:0] pb, logic [31:0] po,
                                 logic [31:0] pin, logic [3:0] press, logic cpu);
        vec_t v;
        v.rst = rst; v.pb = pb; v.po = po; v.pin = pin; v.press = press; v.cpu = cpu;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int mcnt;

    task automatic pwm_run(int n);
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            exp = (mcnt <= int'(pwm_level)) ? ~port_out[7:0] : 8'hFF;
            tick();
            $display("pwm lvl=%0d phase=%0d led=%h", pwm_level, mcnt, led_pad);
            check("led_pwm", k, 32'(led_pad), 32'(exp));
            mcnt = (mcnt + 1) % 4;
        end
    endtask

    initial begin
        // Power-on reset and release stretch
        addn(5, 1, 4'hF, 32'h0, 32'h0,       4'h0, 1);
        addn(3, 0, 4'hF, 32'h0, 32'h0,       4'h0, 1);
        addn(2, 0, 4'hF, 32'h0, 32'h0,       4'h0, 0);
        // Button 1 pressed and held, then released
        addn(6, 0, 4'hD, 32'h0, 32'h0,       4'h0, 0);
        addn(1, 0, 4'hD, 32'h0, 32'h2,       4'h2, 0);
        addn(1, 0, 4'hD, 32'h0, 32'h2,       4'h0, 0);
        addn(2, 0, 4'hD, 32'h0, 32'h20002,   4'h0, 0);
        addn(6, 0, 4'hF, 32'h0, 32'h20002,   4'h0, 0);
        addn(1, 0, 4'hF, 32'h0, 32'h20000,   4'h0, 0);
        // Button 2 glitch of 3 cycles is rejected
        addn(3, 0, 4'hB, 32'h0, 32'h20000,   4'h0, 0);
        addn(4, 0, 4'hF, 32'h0, 32'h20000,   4'h0, 0);
        // Clear strobe edge, then a press while the strobe stays high
        addn(1, 0, 4'hF, 32'h80000000, 32'h20000, 4'h0, 0);
        addn(1, 0, 4'hF, 32'h80000000, 32'h0,     4'h0, 0);
        addn(6, 0, 4'h7, 32'h80000000, 32'h0,     4'h0, 0);
        addn(1, 0, 4'h7, 32'h80000000, 32'h8,     4'h8, 0);
        addn(1, 0, 4'h7, 32'h80000000, 32'h8,     4'h0, 0);
        addn(2, 0, 4'h7, 32'h80000000, 32'h80008, 4'h0, 0);
        // Press of button 2 coincides with a new clear edge: set wins
        addn(6, 0, 4'h3, 32'h0,        32'h80008, 4'h0, 0);
        addn(1, 0, 4'h3, 32'h0,        32'h8000C, 4'h4, 0);
        addn(1, 0, 4'h3, 32'h80000000, 32'h8000C, 4'h0, 0);
        addn(2, 0, 4'h3, 32'h80000000, 32'h4000C, 4'h0, 0);
        // Reset button 0 press and release
        addn(6, 0, 4'h2, 32'h0, 32'h4000C,   4'h0, 0);
        addn(1, 0, 4'h2, 32'h0, 32'h4000D,   4'h1, 1);
        addn(1, 0, 4'h2, 32'h0, 32'h4000D,   4'h0, 1);
        addn(2, 0, 4'h2, 32'h0, 32'h5000D,   4'h0, 1);
        addn(6, 0, 4'h3, 32'h0, 32'h5000D,   4'h0, 1);
        addn(3, 0, 4'h3, 32'h0, 32'h5000C,   4'h0, 1);
        addn(2, 0, 4'h3, 32'h0, 32'h5000C,   4'h0, 0);
        // Reset mid-debounce with pending flags, buttons 1..3 kept pressed
        addn(4, 0, 4'h1, 32'h0, 32'h5000C,   4'h0, 0);
        addn(1, 1, 4'h1, 32'h0, 32'h0,       4'h0, 1);
        addn(3, 0, 4'h1, 32'h0, 32'h0,       4'h0, 1);
        addn(3, 0, 4'h1, 32'h0, 32'h0,       4'h0, 0);
        addn(1, 0, 4'h1, 32'h0, 32'hE,       4'hE, 0);
        addn(1, 0, 4'h1, 32'h0, 32'hE,       4'h0, 0);
        addn(1, 0, 4'h1, 32'h0, 32'hE000E,   4'h0, 0);

        reset = 1'b1; pb_pad = 4'hF; port_out = '0; pwm_level = 2'd0;

        foreach (vecs[r]) begin
            reset = vecs[r].rst; pb_pad = vecs[r].pb; port_out = vecs[r].po;
            tick();
            $display("row %0d rst=%b pb=%h po=%h -> pin=%h press=%h cpu=%b led=%h",
                     r, vecs[r].rst, vecs[r].pb, vecs[r].po, port_in, pb_press, cpu_reset, led_pad);
            check("port_in",   r, port_in,           vecs[r].pin);
            check("pb_press",  r, 32'(pb_press),     32'(vecs[r].press));
            check("cpu_reset", r, 32'(cpu_reset),    32'(vecs[r].cpu));
            check("led_pad",   r, 32'(led_pad),      32'hFF);
        end

        // PWM dimming, phase aligned by a reset pulse
        reset = 1'b1; pb_pad = 4'hF; port_out = 32'hA5; pwm_level = 2'd1;
        tick();
        $display("pwm reset led=%h pin=%h cpu=%b", led_pad, port_in, cpu_reset);
        check("led_reset", 0, 32'(led_pad), 32'hFF);
        check("pin_reset", 0, port_in,      32'h0);
        mcnt  = 0;
        reset = 1'b0;
        pwm_run(8);
        pwm_level = 2'd3;
        pwm_run(8);
        pwm_level = 2'd0;
        pwm_run(4);
        pwm_level = 2'd3;
        pwm_run(2);
        check("cpu_idle", 0, 32'(cpu_reset), 32'h0);

        // Reset while LEDs are lit
        reset = 1'b1;
        tick();
        $display("final reset led=%h pin=%h cpu=%b", led_pad, port_in, cpu_reset);
        check("led_final", 0, 32'(led_pad),   32'hFF);
        check("cpu_final", 0, 32'(cpu_reset), 32'h1);
        check("pin_final", 0, port_in,        32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
